// File: rtl/counter_rr_scheduler_pkg.sv
// Shared definitions for the round-robin counter scheduler.
// State encodings and default sizes, reused by the testbench.
package counter_rr_scheduler_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int CNT_W_DEF = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/mod_cnt_en.sv
// Generic synchronous up-counter with enable and clear.
// Clear beats enable; wrap_tick flags the enabled all-ones step.
module mod_cnt_en #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  output logic [CNT_W-1:0] q,
  output logic             wrap_tick
);

  // wrap_tick is high on the edge that takes q from all-ones back to 0
  always_comb begin
    wrap_tick = en && (q == {CNT_W{1'b1}});
  end

  // count register: reset/clear to 0, else +1 when enabled
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      q <= '0;
    end else if (en) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/counter_rr_scheduler.sv
// Round-robin owner of one shared mod-2^CNT_W counter.
// A grantee keeps the counter until it drops req or the count wraps.
module counter_rr_scheduler
  import counter_rr_scheduler_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] inc,
  output logic [N_REQ-1:0] grant,
  output logic [CNT_W-1:0] cnt_out,
  output logic             wrap,
  output logic             busy
);

  localparam int PW = $clog2(N_REQ);

  state_t           state;
  state_t           state_n;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    ptr_n;
  logic [PW-1:0]    gidx;
  logic [PW-1:0]    gidx_n;
  logic [PW-1:0]    win;
  logic [PW-1:0]    gnext;
  logic [N_REQ-1:0] grant_n;
  logic             found;
  logic             cnt_en;
  logic             cnt_clr;
  logic             drop;
  logic             wrap_tick;

  // first requester at or above the pointer, wrapping round
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      int unsigned idx;
      idx = (int'(ptr) + i) % N_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  // counter control: only the grantee counts, drop or idle clears
  always_comb begin
    drop    = (state == ST_GRANT) && !req[gidx];
    cnt_en  = (state == ST_GRANT) && req[gidx] && inc[gidx];
    cnt_clr = (state == ST_IDLE) || drop;
    gnext   = (int'(gidx) == N_REQ - 1) ? '0 : gidx + 1'b1;
  end

  mod_cnt_en #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk       (clk),
    .reset     (reset),
    .clear     (cnt_clr),
    .en        (cnt_en),
    .q         (cnt_out),
    .wrap_tick (wrap_tick)
  );

  // next state, grant and pointer
  always_comb begin
    state_n = state;
    grant_n = grant;
    ptr_n   = ptr;
    gidx_n  = gidx;
    unique case (state)
      ST_IDLE: begin
        if (found) begin
          state_n      = ST_GRANT;
          grant_n      = '0;
          grant_n[win] = 1'b1;
          gidx_n       = win;
        end
      end
      ST_GRANT: begin
        if (drop || wrap_tick) begin
          state_n = ST_IDLE;
          grant_n = '0;
          ptr_n   = gnext;
        end
      end
      default: begin
        state_n = ST_IDLE;
        grant_n = '0;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      grant <= '0;
      ptr   <= '0;
      gidx  <= '0;
      wrap  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      ptr   <= ptr_n;
      gidx  <= gidx_n;
      wrap  <= wrap_tick;
      busy  <= (state_n == ST_GRANT);
    end
  end

endmodule

// File: tb/tb_counter_rr_scheduler.sv
// Directed testbench for counter_rr_scheduler.
// One task per scenario, inline checks, single summary line.
module tb_counter_rr_scheduler;
  import counter_rr_scheduler_pkg::*;

  localparam int N = N_REQ_DEF;
  localparam int W = CNT_W_DEF;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] inc = '0;
  logic [N-1:0] grant;
  logic [W-1:0] cnt_out;
  logic         wrap;
  logic         busy;

  int checks = 0;
  int errors = 0;

  counter_rr_scheduler #(
    .N_REQ (N),
    .CNT_W (W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .inc     (inc),
    .grant   (grant),
    .cnt_out (cnt_out),
    .wrap    (wrap),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req   = '0;
    inc   = '0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = N'($urandom);
    inc   = N'($urandom);
    step();
    req   = N'($urandom);
    inc   = N'($urandom);
    step();
    checks++;
    if ({grant, cnt_out, wrap, busy} !== '0) begin
      errors++;
      $display("FAIL reset: grant=%b cnt=%0d wrap=%b busy=%b, want all 0",
               grant, cnt_out, wrap, busy);
    end
    reset = 1'b0;
    req   = '0;
    inc   = '0;
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100;
    inc = 4'b0100;
    step();
    checks++;
    if (grant !== 4'b0100 || busy !== 1'b1 || cnt_out !== 3'd0) begin
      errors++;
      $display("FAIL single_grant: grant=%b busy=%b cnt=%0d, want 0100 1 0",
               grant, busy, cnt_out);
    end
    for (int k = 1; k < 8; k++) begin
      step();
      checks++;
      if (cnt_out !== W'(k) || wrap !== 1'b0) begin
        errors++;
        $display("FAIL single_cnt: cnt=%0d wrap=%b, want %0d 0",
                 cnt_out, wrap, k);
      end
    end
    step();
    checks++;
    if (wrap !== 1'b1 || cnt_out !== 3'd0 || grant !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_wrap: wrap=%b cnt=%0d grant=%b busy=%b, want 1 0 0000 0",
               wrap, cnt_out, grant, busy);
    end
    step();
    checks++;
    if (grant !== 4'b0100 || cnt_out !== 3'd0 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL single_regrant: grant=%b cnt=%0d wrap=%b, want 0100 0 0",
               grant, cnt_out, wrap);
    end
  endtask

  task automatic test_rr_all();
    logic [N-1:0] exp;
    do_reset();
    req = 4'b1111;
    inc = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      exp = '0;
      exp[r % N] = 1'b1;
      step();
      checks++;
      if (grant !== exp || cnt_out !== 3'd0) begin
        errors++;
        $display("FAIL rr_grant%0d: grant=%b cnt=%0d, want %b 0",
                 r, grant, cnt_out, exp);
      end
      for (int k = 1; k < 8; k++) step();
      checks++;
      if (cnt_out !== 3'd7 || grant !== exp) begin
        errors++;
        $display("FAIL rr_cnt7_%0d: cnt=%0d grant=%b, want 7 %b",
                 r, cnt_out, grant, exp);
      end
      step();
      checks++;
      if (wrap !== 1'b1 || grant !== 4'b0000 || cnt_out !== 3'd0) begin
        errors++;
        $display("FAIL rr_wrap%0d: wrap=%b grant=%b cnt=%0d, want 1 0000 0",
                 r, wrap, grant, cnt_out);
      end
    end
  endtask

  task automatic test_hold();
    do_reset();
    req = 4'b0001;
    inc = 4'b0001;
    step();
    step();
    step();
    step();
    checks++;
    if (cnt_out !== 3'd3 || grant !== 4'b0001) begin
      errors++;
      $display("FAIL hold_pre: cnt=%0d grant=%b, want 3 0001", cnt_out, grant);
    end
    inc = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (cnt_out !== 3'd3 || grant !== 4'b0001 || wrap !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d: cnt=%0d grant=%b wrap=%b, want 3 0001 0",
                 k, cnt_out, grant, wrap);
      end
    end
    inc = 4'b0001;
    step();
    checks++;
    if (cnt_out !== 3'd4) begin
      errors++;
      $display("FAIL hold_resume: cnt=%0d, want 4", cnt_out);
    end
  endtask

  task automatic test_drop();
    do_reset();
    req = 4'b0010;
    inc = 4'b0010;
    step();
    checks++;
    if (grant !== 4'b0010) begin
      errors++;
      $display("FAIL drop_grant: grant=%b, want 0010", grant);
    end
    req = 4'b1010;
    inc = 4'b1010;
    for (int k = 0; k < 5; k++) step();
    checks++;
    if (cnt_out !== 3'd5 || grant !== 4'b0010) begin
      errors++;
      $display("FAIL drop_cnt5: cnt=%0d grant=%b, want 5 0010", cnt_out, grant);
    end
    req = 4'b1000;
    step();
    checks++;
    if (grant !== 4'b0000 || cnt_out !== 3'd0 || wrap !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL drop_release: grant=%b cnt=%0d wrap=%b busy=%b, want 0000 0 0 0",
               grant, cnt_out, wrap, busy);
    end
    step();
    checks++;
    if (grant !== 4'b1000 || cnt_out !== 3'd0) begin
      errors++;
      $display("FAIL drop_next: grant=%b cnt=%0d, want 1000 0", grant, cnt_out);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    req = 4'b0100;
    inc = 4'b0100;
    for (int k = 0; k < 5; k++) step();
    checks++;
    if (cnt_out !== 3'd4 || grant !== 4'b0100) begin
      errors++;
      $display("FAIL mrst_pre: cnt=%0d grant=%b, want 4 0100", cnt_out, grant);
    end
    req   = 4'b1111;
    inc   = 4'b1111;
    reset = 1'b1;
    step();
    checks++;
    if ({grant, cnt_out, wrap, busy} !== '0) begin
      errors++;
      $display("FAIL mrst_reset: grant=%b cnt=%0d wrap=%b busy=%b, want all 0",
               grant, cnt_out, wrap, busy);
    end
    reset = 1'b0;
    step();
    checks++;
    if (grant !== 4'b0001 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mrst_first: grant=%b busy=%b, want 0001 1", grant, busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr_all();
    test_hold();
    test_drop();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
